d_victim_cache_ctrl: RTL and testbench

Sequencing controller for the data-side victim cache. It holds the tag, valid and dirty state for a small fully-associative victim buffer and drives the external victim data array through a single way-indexed port. It serves one L1 miss at a time: on a hit it swaps the line back to L1, and on a miss it inserts the L1 victim. Dirty lines displaced from the buffer are written back to memory through a valid/ready handshake.

---
 rtl/d_victim_cache_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_d_victim_cache_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_victim_cache_ctrl.sv
// Victim cache sequencer: tag/valid/dirty state plus control of an external data array and memory write-back.
// Latency: hit 3, miss w/o evict 2, clean insert 3, dirty victim 3+N cycles from accept to resp_valid_o.
// Backpressure: one request in flight (req_ready_o only in IDLE); write-back waits on mem_wb_ready_i; response has none.
module d_victim_cache_ctrl #(
    parameter int WAYS_VC      = 4,
    parameter int INDEX_WAY_VC = $clog2(WAYS_VC),
    parameter int TAG_W        = 26,
    parameter int LINE_W       = 128
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [TAG_W-1:0]        req_tag_i,
    input  logic                    evict_valid_i,
    input  logic [TAG_W-1:0]        evict_tag_i,
    input  logic [LINE_W-1:0]       evict_data_i,
    input  logic                    evict_dirty_i,
    output logic                    resp_valid_o,
    output logic                    resp_hit_o,
    output logic [LINE_W-1:0]       resp_data_o,
    output logic                    resp_dirty_o,
    output logic                    vc_we_o,
    output logic [INDEX_WAY_VC-1:0] vc_way_o,
    output logic [LINE_W-1:0]       vc_wdata_o,
    input  logic [LINE_W-1:0]       vc_rdata_i,
    output logic                    mem_wb_valid_o,
    input  logic                    mem_wb_ready_i,
    output logic [TAG_W-1:0]        mem_wb_tag_o,
    output logic [LINE_W-1:0]       mem_wb_data_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_SWAP,
        S_WB,
        S_INSERT,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [TAG_W-1:0]        tag_q [WAYS_VC];
    logic [TAG_W-1:0]        tag_d [WAYS_VC];
    logic [WAYS_VC-1:0]      valid_q, valid_d;
    logic [WAYS_VC-1:0]      dirty_q, dirty_d;
    logic [INDEX_WAY_VC-1:0] rr_q, rr_d;
    logic [INDEX_WAY_VC-1:0] way_sel_q, way_sel_d;

    logic [TAG_W-1:0]        req_tag_q, req_tag_d;
    logic                    ev_vld_q, ev_vld_d;
    logic [TAG_W-1:0]        ev_tag_q, ev_tag_d;
    logic [LINE_W-1:0]       ev_data_q, ev_data_d;
    logic                    ev_dirty_q, ev_dirty_d;

    logic                    resp_hit_q, resp_hit_d;
    logic                    resp_dirty_q, resp_dirty_d;
    logic [LINE_W-1:0]       resp_data_q, resp_data_d;

    logic                    hit_any;
    logic [INDEX_WAY_VC-1:0] hit_way;
    logic                    free_any;
    logic [INDEX_WAY_VC-1:0] free_way;
    logic [INDEX_WAY_VC-1:0] victim_way;

    // Parallel tag match and lowest-index free-way search (descending scan so the lowest index wins).
    always_comb begin
        hit_any  = 1'b0;
        hit_way  = '0;
        free_any = 1'b0;
        free_way = '0;
        for (int i = WAYS_VC - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == req_tag_q)) begin
                hit_any = 1'b1;
                hit_way = INDEX_WAY_VC'(i);
            end
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_way = INDEX_WAY_VC'(i);
            end
        end
        victim_way = free_any ? free_way : rr_q;
    end

    // Next-state, bookkeeping updates and array/write-back strobes.
    always_comb begin
        state_d        = state_q;
        tag_d          = tag_q;
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        rr_d           = rr_q;
        way_sel_d      = way_sel_q;
        req_tag_d      = req_tag_q;
        ev_vld_d       = ev_vld_q;
        ev_tag_d       = ev_tag_q;
        ev_data_d      = ev_data_q;
        ev_dirty_d     = ev_dirty_q;
        resp_hit_d     = resp_hit_q;
        resp_dirty_d   = resp_dirty_q;
        resp_data_d    = resp_data_q;
        vc_we_o        = 1'b0;
        vc_way_o       = way_sel_q;
        mem_wb_valid_o = 1'b0;
        resp_valid_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    req_tag_d  = req_tag_i;
                    ev_vld_d   = evict_valid_i;
                    ev_tag_d   = evict_tag_i;
                    ev_data_d  = evict_data_i;
                    ev_dirty_d = evict_dirty_i;
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                // Read port points at the hit way so its line can be captured this cycle.
                vc_way_o = hit_way;
                if (hit_any) begin
                    way_sel_d    = hit_way;
                    resp_hit_d   = 1'b1;
                    resp_data_d  = vc_rdata_i;
                    resp_dirty_d = dirty_q[hit_way];
                    state_d      = S_SWAP;
                end else begin
                    resp_hit_d   = 1'b0;
                    resp_dirty_d = 1'b0;
                    if (ev_vld_q) begin
                        way_sel_d = victim_way;
                        if (valid_q[victim_way] && dirty_q[victim_way]) begin
                            state_d = S_WB;
                        end else begin
                            state_d = S_INSERT;
                        end
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_SWAP: begin
                // The hit line moves to L1; its slot takes the L1 victim or becomes free.
                if (ev_vld_q) begin
                    vc_we_o            = 1'b1;
                    tag_d[way_sel_q]   = ev_tag_q;
                    dirty_d[way_sel_q] = ev_dirty_q;
                    valid_d[way_sel_q] = 1'b1;
                end else begin
                    valid_d[way_sel_q] = 1'b0;
                end
                state_d = S_RESP;
            end
            S_WB: begin
                mem_wb_valid_o = 1'b1;
                if (mem_wb_ready_i) begin
                    state_d = S_INSERT;
                end
            end
            S_INSERT: begin
                vc_we_o            = 1'b1;
                tag_d[way_sel_q]   = ev_tag_q;
                dirty_d[way_sel_q] = ev_dirty_q;
                valid_d[way_sel_q] = 1'b1;
                // Only a true replacement advances the round-robin pointer.
                if (valid_q[way_sel_q]) begin
                    rr_d = rr_q + INDEX_WAY_VC'(1);
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Ready is masked by reset so it stays low while rst_ni is asserted.
    assign req_ready_o   = (state_q == S_IDLE) && rst_ni;
    assign vc_wdata_o    = ev_data_q;
    assign resp_hit_o    = resp_hit_q;
    assign resp_dirty_o  = resp_dirty_q;
    assign resp_data_o   = resp_data_q;
    assign mem_wb_tag_o  = (state_q == S_WB) ? tag_q[way_sel_q] : '0;
    assign mem_wb_data_o = (state_q == S_WB) ? vc_rdata_i : '0;

    // State and bookkeeping registers; reset invalidates every entry without touching the data array.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            tag_q        <= '{default: '0};
            valid_q      <= '0;
            dirty_q      <= '0;
            rr_q         <= '0;
            way_sel_q    <= '0;
            req_tag_q    <= '0;
            ev_vld_q     <= 1'b0;
            ev_tag_q     <= '0;
            ev_data_q    <= '0;
            ev_dirty_q   <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_dirty_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            rr_q         <= rr_d;
            way_sel_q    <= way_sel_d;
            req_tag_q    <= req_tag_d;
            ev_vld_q     <= ev_vld_d;
            ev_tag_q     <= ev_tag_d;
            ev_data_q    <= ev_data_d;
            ev_dirty_q   <= ev_dirty_d;
            resp_hit_q   <= resp_hit_d;
            resp_dirty_q <= resp_dirty_d;
            resp_data_q  <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_d_victim_cache_ctrl.sv
// Bench for d_victim_cache_ctrl: directed scenarios plus randomized traffic against a behavioural cache model.
// Latency: not applicable.
// Backpressure: the bench plays the memory side and stalls write-backs by a chosen number of cycles.
module tb_d_victim_cache_ctrl;

    localparam int W  = 4;
    localparam int IW = 2;
    localparam int TW = 26;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [TW-1:0] req_tag = '0;
    logic          ev_valid = 1'b0;
    logic [TW-1:0] ev_tag = '0;
    logic [LW-1:0] ev_data = '0;
    logic          ev_dirty = 1'b0;
    logic          resp_valid, resp_hit, resp_dirty;
    logic [LW-1:0] resp_data;
    logic          vc_we;
    logic [IW-1:0] vc_way;
    logic [LW-1:0] vc_wdata, vc_rdata;
    logic          wb_valid;
    logic          wb_ready = 1'b0;
    logic [TW-1:0] wb_tag;
    logic [LW-1:0] wb_data;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the victim buffer contents.
    logic [TW-1:0] m_tag   [W];
    logic [LW-1:0] m_data  [W];
    bit            m_valid [W];
    bit            m_dirty [W];
    int            m_rr;

    // External data array owned by the bench.
    logic [LW-1:0] arr [W];
    assign vc_rdata = arr[vc_way];
    always @(posedge clk) if (vc_we) arr[vc_way] <= vc_wdata;

    always #5 clk = ~clk;

    d_victim_cache_ctrl #(.WAYS_VC(W), .INDEX_WAY_VC(IW), .TAG_W(TW), .LINE_W(LW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_tag_i(req_tag),
        .evict_valid_i(ev_valid), .evict_tag_i(ev_tag), .evict_data_i(ev_data), .evict_dirty_i(ev_dirty),
        .resp_valid_o(resp_valid), .resp_hit_o(resp_hit), .resp_data_o(resp_data), .resp_dirty_o(resp_dirty),
        .vc_we_o(vc_we), .vc_way_o(vc_way), .vc_wdata_o(vc_wdata), .vc_rdata_i(vc_rdata),
        .mem_wb_valid_o(wb_valid), .mem_wb_ready_i(wb_ready), .mem_wb_tag_o(wb_tag), .mem_wb_data_o(wb_data)
    );

    function automatic logic [LW-1:0] fill_line(input logic [7:0] b);
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 8; i++) v[i*8 +: 8] = b;
        return v;
    endfunction

    function automatic bit resident(input logic [TW-1:0] t);
        for (int i = 0; i < W; i++) if (m_valid[i] && m_tag[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_rr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        wb_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full transaction: model predicts, bench drives, observations compared inline.
    task automatic run_req(input logic [TW-1:0] t, input bit ev, input logic [TW-1:0] et,
                           input logic [LW-1:0] ed, input bit edirty, input int stall,
                           input string name, output int obs_lat, output int obs_way);
        int hw, v, exp_lat, exp_we_way, exp_wb_cnt;
        bit exp_hit, exp_rdirty;
        logic [LW-1:0] exp_rdata, exp_wb_data, wb_d0, got_data, we_data;
        logic [TW-1:0] exp_wb_tag, wb_t0;
        int we_cnt, wb_cnt, got, we_way;
        bit ready_bad, unstable, got_hit, got_dirty;

        hw = -1;
        for (int i = W - 1; i >= 0; i--) if (m_valid[i] && m_tag[i] == t) hw = i;
        exp_hit = (hw >= 0);
        exp_rdirty = 1'b0;
        exp_rdata = '0;
        exp_we_way = -1;
        exp_wb_cnt = 0;
        exp_wb_tag = '0;
        exp_wb_data = '0;
        if (exp_hit) begin
            exp_lat = 3;
            exp_rdata = m_data[hw];
            exp_rdirty = m_dirty[hw];
            if (ev) begin
                exp_we_way = hw;
                m_tag[hw] = et; m_data[hw] = ed; m_dirty[hw] = edirty;
            end else begin
                m_valid[hw] = 1'b0;
            end
        end else if (!ev) begin
            exp_lat = 2;
        end else begin
            v = -1;
            for (int i = W - 1; i >= 0; i--) if (!m_valid[i]) v = i;
            if (v < 0) begin
                v = m_rr;
                m_rr = (m_rr + 1) % W;
            end
            if (m_valid[v] && m_dirty[v]) begin
                exp_wb_cnt = stall + 1;
                exp_wb_tag = m_tag[v];
                exp_wb_data = m_data[v];
            end
            exp_lat = 3 + exp_wb_cnt;
            exp_we_way = v;
            m_tag[v] = et; m_data[v] = ed; m_dirty[v] = edirty; m_valid[v] = 1'b1;
        end

        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_req: got %0b expected 1", name, req_ready);
        end
        req_tag = t; ev_valid = ev; ev_tag = et; ev_data = ed; ev_dirty = edirty;
        req_valid = 1'b1;
        wb_ready = 1'b0;
        @(posedge clk);
        we_cnt = 0; wb_cnt = 0; got = 0; we_way = -1; we_data = '0;
        ready_bad = 0; unstable = 0; got_hit = 0; got_dirty = 0; got_data = '0;
        wb_t0 = '0; wb_d0 = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (req_ready !== 1'b0) ready_bad = 1;
            if (vc_we === 1'b1) begin
                we_cnt++;
                we_way = int'(vc_way);
                we_data = vc_wdata;
            end
            if (wb_valid === 1'b1) begin
                wb_cnt++;
                if (wb_cnt == 1) begin
                    wb_t0 = wb_tag; wb_d0 = wb_data;
                end else if (wb_tag !== wb_t0 || wb_data !== wb_d0) begin
                    unstable = 1;
                end
                wb_ready = (wb_cnt > stall);
            end else begin
                wb_ready = 1'b0;
            end
            if (resp_valid === 1'b1) begin
                got = c;
                got_hit = resp_hit; got_dirty = resp_dirty; got_data = resp_data;
                break;
            end
        end
        wb_ready = 1'b0;
        obs_lat = got;
        obs_way = we_way;

        checks++;
        if (got != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d (0 = no response)", name, got, exp_lat);
        end
        checks++;
        if (ready_bad) begin
            errors++;
            $display("FAIL %s ready_busy: got 1 expected 0 while busy", name);
        end
        checks++;
        if (got_hit !== exp_hit || got_dirty !== exp_rdirty) begin
            errors++;
            $display("FAIL %s hit_dirty: got %0b/%0b expected %0b/%0b", name, got_hit, got_dirty, exp_hit, exp_rdirty);
        end
        if (exp_hit) begin
            checks++;
            if (got_data !== exp_rdata) begin
                errors++;
                $display("FAIL %s resp_data: got %h expected %h", name, got_data, exp_rdata);
            end
        end
        checks++;
        if (we_cnt != (exp_we_way >= 0 ? 1 : 0) || (exp_we_way >= 0 && (we_way != exp_we_way || we_data !== ed))) begin
            errors++;
            $display("FAIL %s array_write: got cnt %0d way %0d expected way %0d", name, we_cnt, we_way, exp_we_way);
        end
        checks++;
        if (wb_cnt != exp_wb_cnt) begin
            errors++;
            $display("FAIL %s wb_cycles: got %0d expected %0d", name, wb_cnt, exp_wb_cnt);
        end
        if (exp_wb_cnt > 0) begin
            checks++;
            if (unstable || wb_t0 !== exp_wb_tag || wb_d0 !== exp_wb_data) begin
                errors++;
                $display("FAIL %s wb_payload: got tag %h stable %0b expected tag %h", name, wb_t0, !unstable, exp_wb_tag);
            end
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_resp: got valid %0b ready %0b expected 0/1", name, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_hit, resp_dirty, vc_we, wb_valid} !== 6'b0 ||
            resp_data !== '0 || vc_way !== '0 || vc_wdata !== '0 || wb_tag !== '0 || wb_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready %0b resp %0b we %0b wb %0b expected all 0",
                     req_ready, resp_valid, vc_we, wb_valid);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %0b expected 1", req_ready);
        end
    endtask

    task automatic test_cold_insert_and_hit_swap();
        int lat, way;
        run_req(26'h10, 1, 26'h20, fill_line(8'hA5), 0, 0, "cold_insert", lat, way);
        checks++;
        if (lat != 3 || way != 0) begin
            errors++;
            $display("FAIL cold_insert_way: got lat %0d way %0d expected 3/0", lat, way);
        end
        run_req(26'h20, 1, 26'h30, fill_line(8'h3C), 1, 0, "hit_swap", lat, way);
        checks++;
        if (way != 0) begin
            errors++;
            $display("FAIL hit_swap_way: got %0d expected 0", way);
        end
        // Pulling 0x30 back out shows way 0 holds it dirty.
        run_req(26'h30, 0, 26'h0, '0, 0, 0, "hit_swapped_line", lat, way);
    endtask

    task automatic test_fill_rr();
        int lat, way;
        do_reset();
        for (int i = 0; i < 4; i++)
            run_req(26'h50 + i, 1, 26'h40 + i, fill_line(8'h40 + 8'(i)), 0, 0, "fill", lat, way);
        run_req(26'h60, 1, 26'h44, fill_line(8'h44), 0, 0, "rr_fifth", lat, way);
        checks++;
        if (way != 0) begin
            errors++;
            $display("FAIL rr_fifth_way: got %0d expected 0", way);
        end
        run_req(26'h61, 1, 26'h45, fill_line(8'h45), 0, 0, "rr_sixth", lat, way);
        checks++;
        if (way != 1) begin
            errors++;
            $display("FAIL rr_sixth_way: got %0d expected 1", way);
        end
    endtask

    task automatic test_dirty_wb_stall();
        int lat, way;
        do_reset();
        for (int i = 0; i < 4; i++)
            run_req(26'h70 + i, 1, 26'h80 + i, fill_line(8'h80 + 8'(i)), (i == 0), 0, "wb_fill", lat, way);
        run_req(26'h90, 1, 26'h91, fill_line(8'h91), 0, 3, "dirty_wb", lat, way);
        checks++;
        if (lat != 7 || way != 0) begin
            errors++;
            $display("FAIL dirty_wb_timing: got lat %0d way %0d expected 7/0", lat, way);
        end
    endtask

    task automatic test_miss_no_evict();
        int lat, way;
        run_req(26'h1FF, 0, 26'h0, '0, 0, 0, "miss_no_evict", lat, way);
        checks++;
        if (lat != 2 || way != -1) begin
            errors++;
            $display("FAIL miss_no_evict_timing: got lat %0d write way %0d expected 2/-1", lat, way);
        end
    endtask

    task automatic test_random();
        int lat, way;
        logic [TW-1:0] t, et;
        bit ev, found;
        for (int n = 0; n < 40; n++) begin
            t = 26'h300 + 26'($urandom_range(0, 7));
            ev = ($urandom_range(0, 3) != 0);
            found = 0;
            et = '0;
            for (int k = 0; k < 16 && !found; k++) begin
                et = 26'h300 + 26'($urandom_range(0, 7));
                if (et != t && !resident(et)) found = 1;
            end
            if (!found) ev = 0;
            run_req(t, ev, et, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), "random", lat, way);
        end
    endtask

    task automatic test_reset_mid_wb();
        int lat, way;
        bit seen;
        do_reset();
        for (int i = 0; i < 4; i++)
            run_req(26'h100 + i, 1, 26'h200 + i, fill_line(8'h20 + 8'(i)), 1, 0, "rst_fill", lat, way);
        @(negedge clk);
        req_tag = 26'h250; ev_valid = 1'b1; ev_tag = 26'h251; ev_data = fill_line(8'h51); ev_dirty = 1'b0;
        req_valid = 1'b1;
        wb_ready = 1'b0;
        @(posedge clk);
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (wb_valid === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_wb_reach: got no write-back expected mem_wb_valid_o");
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (wb_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_wb_drop: got valid %0b ready %0b expected 0/0", wb_valid, req_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wb_release: got ready %0b wb %0b expected 1/0", req_ready, wb_valid);
        end
        for (int i = 0; i < 4; i++)
            run_req(26'h200 + i, 0, 26'h0, '0, 0, 0, "rst_invalid", lat, way);
    endtask

    initial begin
        test_reset();
        test_cold_insert_and_hit_swap();
        test_miss_no_evict();
        test_fill_rr();
        test_dirty_wb_stall();
        test_random();
        test_reset_mid_wb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
